reg_op_seq: RTL

//  Multi-cycle register-to-register operation sequencer; sits beside the 8x32 register file.
//  - Upstream role: drives the write port. Downstream role: consumes the two read ports.
//  - Accepts one command {op, rd, rs, rt} per valid/ready handshake.
//  - Reads rs/rt, computes one ALU op or a 32-cycle shift-add multiply, writes the result to rd.

---
 rtl/reg_op_seq_pkg.sv | 21 ++
 rtl/reg_op_seq_mul32.sv | 58 +++++
 rtl/reg_op_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/reg_op_seq_pkg.sv
// Shared encodings for the register-to-register operation sequencer:
// FSM state type and operation codes.
package reg_op_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_EX   = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

endpackage

// File: rtl/reg_op_seq_mul32.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, low WIDTH
// bits of the unsigned product only.
module reg_op_seq_mul32 #(
   parameter int WIDTH   = 32,
   parameter int MUL_CYC = 32
) (
   input  logic             clk,
   input  logic             cr_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic [WIDTH-1:0] o_p
);

   localparam int             CW   = $clog2(MUL_CYC);
   localparam logic [CW-1:0]  LAST = CW'(MUL_CYC - 1);

   logic             r_run;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] w_sum;

   assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
   // Busy drops on the final iteration cycle, when o_p already holds the product.
   assign o_busy = r_run && (r_cnt != LAST);
   assign o_p    = w_sum;

   always_ff @(posedge clk or negedge cr_n) begin
      if (!cr_n) begin
         r_run <= 1'b0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_cnt <= '0;
      end else if (r_run) begin
         if (r_cnt == LAST) begin
            r_run <= 1'b0;
         end
         r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_start) begin
         r_mcand  <= i_a;
         r_mplier <= i_b;
         r_acc    <= '0;
      end else if (r_run) begin
         r_acc    <= w_sum;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end
   end

endmodule

// File: rtl/reg_op_seq.sv
// Multi-cycle register-to-register operation sequencer: reads rs/rt from the
// register file, runs one ALU op or a sequential multiply, writes rd back.
module reg_op_seq
   import reg_op_seq_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int AW      = 3,
   parameter int MUL_CYC = 32
) (
   input  logic             clk,
   input  logic             cr_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AW-1:0]    cmd_rd,
   input  logic [AW-1:0]    cmd_rs,
   input  logic [AW-1:0]    cmd_rt,
   output logic [AW-1:0]    Addr_A,
   output logic [AW-1:0]    Addr_B,
   input  logic [WIDTH-1:0] QA,
   input  logic [WIDTH-1:0] QB,
   output logic             WE,
   output logic [AW-1:0]    Addr_W,
   output logic [WIDTH-1:0] Di,
   output logic             busy,
   output logic             done
);

   localparam int SHW = $clog2(WIDTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_op;
   logic [AW-1:0]    r_rd;
   logic [AW-1:0]    r_addr_a;
   logic [AW-1:0]    r_addr_b;
   logic [AW-1:0]    r_addr_w;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_di;
   logic [WIDTH-1:0] w_alu;
   logic [WIDTH-1:0] w_mul_p;
   logic             w_accept;
   logic             w_mul_start;
   logic             w_mul_busy;
   logic             w_ex_done;

   assign w_accept  = cmd_valid && (r_state == ST_IDLE);
   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign WE        = (r_state == ST_WB);
   assign done      = (r_state == ST_WB);
   assign Addr_A    = r_addr_a;
   assign Addr_B    = r_addr_b;
   assign Addr_W    = r_addr_w;
   assign Di        = r_di;

   always_ff @(posedge clk or negedge cr_n) begin
      if (!cr_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mul_start = 1'b0;
      w_ex_done   = 1'b0;
      case (r_state)
         ST_IDLE: if (cmd_valid) w_state_nxt = ST_RD;
         ST_RD: begin
            w_state_nxt = ST_EX;
            w_mul_start = (r_op == OP_MUL);
         end
         ST_EX: begin
            if ((r_op != OP_MUL) || !w_mul_busy) begin
               w_state_nxt = ST_WB;
               w_ex_done   = 1'b1;
            end
         end
         ST_WB:   w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Command fields and operands need no reset: they are only consumed after being loaded.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op <= cmd_op;
         r_rd <= cmd_rd;
      end
      if (r_state == ST_RD) begin
         r_a <= QA;
         r_b <= QB;
      end
   end

   always_ff @(posedge clk or negedge cr_n) begin
      if (!cr_n) begin
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_addr_w <= '0;
         r_di     <= '0;
      end else begin
         if (w_accept) begin
            r_addr_a <= cmd_rs;
            r_addr_b <= cmd_rt;
         end
         if (w_ex_done) begin
            r_addr_w <= r_rd;
            r_di     <= (r_op == OP_MUL) ? w_mul_p : w_alu;
         end
      end
   end

   always_comb begin
      w_alu = '0;
      case (r_op)
         OP_ADD:  w_alu = r_a + r_b;
         OP_SUB:  w_alu = r_a - r_b;
         OP_AND:  w_alu = r_a & r_b;
         OP_OR:   w_alu = r_a | r_b;
         OP_XOR:  w_alu = r_a ^ r_b;
         OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
         OP_SLL:  w_alu = r_a << r_b[SHW-1:0];
         OP_MUL:  w_alu = '0;
         default: w_alu = '0;
      endcase
   end

   // Multiplier loads straight from the read ports on the RD exit edge, in step with r_a/r_b.
   reg_op_seq_mul32 #(
      .WIDTH   (WIDTH),
      .MUL_CYC (MUL_CYC)
   ) u_mul (
      .clk     (clk),
      .cr_n    (cr_n),
      .i_start (w_mul_start),
      .i_a     (QA),
      .i_b     (QB),
      .o_busy  (w_mul_busy),
      .o_p     (w_mul_p)
   );

endmodule
